ddr_read_arbiter: RTL and testbench

//  Shares the single DDR read channel among NUM_REQ requesters (ternary_matmul and the other FUs).

---
 rtl/config_pkg.sv | 18 +
 rtl/ddr_arb_id_fifo.sv | 59 +++++
 rtl/ddr_read_arbiter.sv | 159 +++++++++++++++
 tb/tb_ddr_read_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared configuration types for the DDR side of the accelerator.
// Holds the DDR bus types plus the read-arbiter requester ID and FSM state.
package config_pkg;

  typedef logic [31:0] ddr_address_t;
  typedef logic [63:0] ddr_data_t;

  localparam int DDR_ARB_NUM_REQ = 4;

  typedef logic [$clog2(DDR_ARB_NUM_REQ)-1:0] ddr_req_id_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DRAINED
  } ddr_arb_state_e;

endpackage

// File: rtl/ddr_arb_id_fifo.sv
// Synchronous FIFO of requester IDs, one entry per outstanding DDR read.
// Head is the owner of the oldest unreturned read; DEPTH must be a power of 2.
module ddr_arb_id_fifo
  import config_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  ddr_req_id_t      push_id_i,
  input  logic             pop_i,
  output ddr_req_id_t      head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  ddr_req_id_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem[rd_ptr];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage is write-only on push; contents need no reset since count gates reads.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_id_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2; count tracks occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ddr_read_arbiter.sv
// Round-robin arbiter sharing the single DDR read channel among NUM_REQ requesters.
// Each issued read's owner is queued in an ID FIFO so in-order responses route back.
// Optional feature: define DDR_ARB_STATS_EN to add per-requester grant counters (grant_cnt_o).
// NUM_REQ must not exceed DDR_ARB_NUM_REQ, since IDs are stored as ddr_req_id_t.
module ddr_read_arbiter
  import config_pkg::*;
#(
  parameter int NUM_REQ = DDR_ARB_NUM_REQ,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  ddr_address_t [NUM_REQ-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output ddr_data_t                 rsp_data_o,
  output ddr_address_t              ddr_address_o,
  output logic                      ddr_r_en_o,
  input  ddr_data_t                 ddr_r_data_i,
  input  logic                      ddr_r_valid_i,
  input  logic                      drain_i,
  output logic                      drained_o,
  output logic                      err_o,
  output logic [CNT_W-1:0]          outstanding_o
`ifdef DDR_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0]  grant_cnt_o
`endif
);

  ddr_arb_state_e   state_q;
  ddr_req_id_t      rr_ptr;
  ddr_req_id_t      grant_idx;
  ddr_req_id_t      fifo_head;
  logic             grant_any;
  logic             can_issue;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [CNT_W-1:0] fifo_count;

  assign outstanding_o = fifo_count;
  assign drained_o     = (state_q == DRAINED);
  assign pop           = ddr_r_valid_i && !fifo_empty;
  assign can_issue     = (state_q == RUN) && !drain_i && !fifo_full;

  ddr_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (grant_any),
    .push_id_i (grant_idx),
    .pop_i     (pop),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Pick the first valid requester after the last grant, wrapping modulo NUM_REQ.
  always_comb begin
    int          cand;
    ddr_req_id_t cand_id;
    cand        = 0;
    cand_id     = '0;
    grant_any   = 1'b0;
    grant_idx   = rr_ptr;
    req_ready_o = '0;
    if (can_issue) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        cand    = (int'(rr_ptr) + i) % NUM_REQ;
        cand_id = ddr_req_id_t'(cand);
        if (!grant_any && req_valid_i[cand_id]) begin
          grant_any = 1'b1;
          grant_idx = cand_id;
        end
      end
    end
    if (grant_any) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // Round-robin pointer remembers the last winner; it moves only on a grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= ddr_req_id_t'(NUM_REQ - 1);
    end else if (grant_any) begin
      rr_ptr <= grant_idx;
    end
  end

  // Register the granted address onto the DDR read port one cycle after the grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ddr_r_en_o    <= 1'b0;
      ddr_address_o <= '0;
    end else begin
      ddr_r_en_o <= grant_any;
      if (grant_any) begin
        ddr_address_o <= req_addr_i[grant_idx];
      end
    end
  end

  // Route each DDR return to the FIFO head owner; flag returns nobody asked for.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      if (pop) begin
        rsp_valid_o[fifo_head] <= 1'b1;
        rsp_data_o             <= ddr_r_data_i;
      end
      if (ddr_r_valid_i && fifo_empty) begin
        err_o <= 1'b1;
      end
    end
  end

  // Drain handshake: stop granting, wait for the channel to empty, release on drain_i low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (drain_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!drain_i)              state_q <= RUN;
          else if (fifo_count == '0) state_q <= DRAINED;
        end
        DRAINED: begin
          if (!drain_i) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef DDR_ARB_STATS_EN
  // One wrapping counter per requester, bumped only for the granted index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_cnt_o <= '0;
    end else if (grant_any) begin
      grant_cnt_o[grant_idx] <= grant_cnt_o[grant_idx] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Directed bench for ddr_read_arbiter with hand-computed expectations.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_ddr_read_arbiter;
  import config_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 4;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic [NUM_REQ-1:0]         req_valid_i;
  ddr_address_t [NUM_REQ-1:0] req_addr_i;
  logic [NUM_REQ-1:0]         req_ready_o;
  logic [NUM_REQ-1:0]         rsp_valid_o;
  ddr_data_t                  rsp_data_o;
  ddr_address_t               ddr_address_o;
  logic                       ddr_r_en_o;
  ddr_data_t                  ddr_r_data_i;
  logic                       ddr_r_valid_i;
  logic                       drain_i;
  logic                       drained_o;
  logic                       err_o;
  logic [CNT_W-1:0]           outstanding_o;
`ifdef DDR_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0]   grant_cnt_o;
`endif

  int checks_made = 0;
  int fail_count  = 0;

  ddr_read_arbiter #(
    .NUM_REQ         (NUM_REQ),
    .MAX_OUTSTANDING (8)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_addr_i    (req_addr_i),
    .req_ready_o   (req_ready_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_data_o    (rsp_data_o),
    .ddr_address_o (ddr_address_o),
    .ddr_r_en_o    (ddr_r_en_o),
    .ddr_r_data_i  (ddr_r_data_i),
    .ddr_r_valid_i (ddr_r_valid_i),
    .drain_i       (drain_i),
    .drained_o     (drained_o),
    .err_o         (err_o),
    .outstanding_o (outstanding_o)
`ifdef DDR_ARB_STATS_EN
    ,
    .grant_cnt_o   (grant_cnt_o)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk_i = ~clk_i;

  task automatic nextCycle();
    @(negedge clk_i);
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic drain,
                               input logic rvalid, input ddr_data_t rdata);
    req_valid_i   = valid;
    drain_i       = drain;
    ddr_r_valid_i = rvalid;
    ddr_r_data_i  = rdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks_made++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    rst_i = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0, 64'h0);
    nextCycle();
    nextCycle();
    rst_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) req_addr_i[i] = '0;
    resetDut();

    // Reset state
    checkOutput("rst_ready",   64'(req_ready_o),   64'h0);
    checkOutput("rst_ren",     64'(ddr_r_en_o),    64'h0);
    checkOutput("rst_addr",    64'(ddr_address_o), 64'h0);
    checkOutput("rst_rsp",     64'(rsp_valid_o),   64'h0);
    checkOutput("rst_data",    64'(rsp_data_o),    64'h0);
    checkOutput("rst_drained", 64'(drained_o),     64'h0);
    checkOutput("rst_err",     64'(err_o),         64'h0);
    checkOutput("rst_outst",   64'(outstanding_o), 64'h0);

    // Single requester 1, address 0x40, data 0xAB
    req_addr_i[1] = 32'h40;
    applyStimulus(4'b0010, 1'b0, 1'b0, 64'h0);
    checkOutput("single_ready", 64'(req_ready_o), 64'h2);
    nextCycle();
    applyStimulus(4'b0000, 1'b0, 1'b0, 64'h0);
    checkOutput("single_ren",   64'(ddr_r_en_o),    64'h1);
    checkOutput("single_addr",  64'(ddr_address_o), 64'h40);
    checkOutput("single_outst", 64'(outstanding_o), 64'h1);
    nextCycle();
    checkOutput("single_ren_off", 64'(ddr_r_en_o), 64'h0);
    applyStimulus(4'b0000, 1'b0, 1'b1, 64'hAB);
    nextCycle();
    applyStimulus(4'b0000, 1'b0, 1'b0, 64'h0);
    checkOutput("single_rsp",    64'(rsp_valid_o),   64'h2);
    checkOutput("single_data",   64'(rsp_data_o),    64'hAB);
    checkOutput("single_outst0", 64'(outstanding_o), 64'h0);
    nextCycle();
    checkOutput("single_rsp_off", 64'(rsp_valid_o), 64'h0);
    checkOutput("single_hold",    64'(rsp_data_o),  64'hAB);
    checkOutput("single_err",     64'(err_o),       64'h0);
`ifdef DDR_ARB_STATS_EN
    checkOutput("stats_single1", 64'(grant_cnt_o[1]), 64'h1);
    checkOutput("stats_single0", 64'(grant_cnt_o[0]), 64'h0);
`endif

    // All four valid, DDR silent: order 0,1,2,3,0,1,2,3 then full
    resetDut();
    for (int i = 0; i < NUM_REQ; i++) req_addr_i[i] = 32'h100 + 32'(i);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0, 64'h0);
      checkOutput("rr_ready", 64'(req_ready_o), 64'(1) << (k % 4));
      nextCycle();
      checkOutput("rr_ren",  64'(ddr_r_en_o),    64'h1);
      checkOutput("rr_addr", 64'(ddr_address_o), 64'(32'h100 + 32'(k % 4)));
    end
    applyStimulus(4'b1111, 1'b0, 1'b0, 64'h0);
    checkOutput("full_ready", 64'(req_ready_o),   64'h0);
    checkOutput("full_outst", 64'(outstanding_o), 64'h8);
    nextCycle();
    checkOutput("full_ren",   64'(ddr_r_en_o),  64'h0);
    checkOutput("full_ready2", 64'(req_ready_o), 64'h0);
`ifdef DDR_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++)
      checkOutput("stats_rr", 64'(grant_cnt_o[i]), 64'h2);
`endif

    // One return at full: count 7, requester 0 granted next
    applyStimulus(4'b1111, 1'b0, 1'b1, 64'h1000);
    checkOutput("full_ret_ready", 64'(req_ready_o), 64'h0);
    nextCycle();
    applyStimulus(4'b1111, 1'b0, 1'b0, 64'h0);
    checkOutput("ret_rsp",   64'(rsp_valid_o),   64'h1);
    checkOutput("ret_data",  64'(rsp_data_o),    64'h1000);
    checkOutput("ret_outst", 64'(outstanding_o), 64'h7);
    checkOutput("ret_ready", 64'(req_ready_o),   64'h1);
    nextCycle();

    // Drain with 8 outstanding; owners queued are 1,2,3,0,1,2,3,0
    applyStimulus(4'b1111, 1'b1, 1'b0, 64'h0);
    checkOutput("drain_outst", 64'(outstanding_o), 64'h8);
    checkOutput("drain_ren",   64'(ddr_r_en_o),    64'h1);
    checkOutput("drain_addr",  64'(ddr_address_o), 64'h100);
    checkOutput("drain_ready", 64'(req_ready_o),   64'h0);
    nextCycle();
    checkOutput("drain_not_done", 64'(drained_o), 64'h0);
    for (int j = 0; j < 8; j++) begin
      applyStimulus(4'b1111, 1'b1, 1'b1, 64'h2000 + 64'(j));
      checkOutput("drain_ready_blk", 64'(req_ready_o), 64'h0);
      nextCycle();
      checkOutput("drain_rsp",  64'(rsp_valid_o), 64'(1) << ((j + 1) % 4));
      checkOutput("drain_data", 64'(rsp_data_o),  64'h2000 + 64'(j));
    end
    applyStimulus(4'b1111, 1'b1, 1'b0, 64'h0);
    checkOutput("drain_outst0",  64'(outstanding_o), 64'h0);
    checkOutput("drain_pending", 64'(drained_o),     64'h0);
    nextCycle();
    checkOutput("drained",        64'(drained_o),   64'h1);
    checkOutput("drained_ready",  64'(req_ready_o), 64'h0);
    applyStimulus(4'b1111, 1'b0, 1'b0, 64'h0);
    checkOutput("release_ready0", 64'(req_ready_o), 64'h0);
    nextCycle();
    checkOutput("release_drained", 64'(drained_o),   64'h0);
    checkOutput("release_ready",   64'(req_ready_o), 64'h2);
    applyStimulus(4'b0000, 1'b0, 1'b0, 64'h0);

    // Spurious return right after reset
    resetDut();
    applyStimulus(4'b0000, 1'b0, 1'b1, 64'h55);
    nextCycle();
    applyStimulus(4'b0000, 1'b0, 1'b0, 64'h0);
    checkOutput("spur_err",   64'(err_o),         64'h1);
    checkOutput("spur_rsp",   64'(rsp_valid_o),   64'h0);
    checkOutput("spur_outst", 64'(outstanding_o), 64'h0);
    nextCycle();
    checkOutput("spur_err_hold", 64'(err_o),       64'h1);
    checkOutput("spur_rsp_hold", 64'(rsp_valid_o), 64'h0);

    // Grant and return together at count 5
    resetDut();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0001, 1'b0, 1'b0, 64'h0);
      nextCycle();
    end
    applyStimulus(4'b0000, 1'b0, 1'b0, 64'h0);
    checkOutput("five_outst", 64'(outstanding_o), 64'h5);
    applyStimulus(4'b0001, 1'b0, 1'b1, 64'h77);
    checkOutput("both_ready", 64'(req_ready_o), 64'h1);
    nextCycle();
    applyStimulus(4'b0000, 1'b0, 1'b0, 64'h0);
    checkOutput("both_outst", 64'(outstanding_o), 64'h5);
    checkOutput("both_rsp",   64'(rsp_valid_o),   64'h1);
    checkOutput("both_data",  64'(rsp_data_o),    64'h77);
    checkOutput("both_ren",   64'(ddr_r_en_o),    64'h1);
`ifdef DDR_ARB_STATS_EN
    checkOutput("stats_both0", 64'(grant_cnt_o[0]), 64'h6);
    checkOutput("stats_both1", 64'(grant_cnt_o[1]), 64'h0);
`endif

    // Drop to 3 outstanding, then reset mid-traffic
    applyStimulus(4'b0000, 1'b0, 1'b1, 64'h88);
    nextCycle();
    applyStimulus(4'b0000, 1'b0, 1'b1, 64'h99);
    nextCycle();
    applyStimulus(4'b0000, 1'b0, 1'b0, 64'h0);
    checkOutput("three_outst", 64'(outstanding_o), 64'h3);
    checkOutput("three_data",  64'(rsp_data_o),    64'h99);
    rst_i = 1'b1;
    nextCycle();
    checkOutput("midrst_outst", 64'(outstanding_o), 64'h0);
    checkOutput("midrst_rsp",   64'(rsp_valid_o),   64'h0);
    checkOutput("midrst_data",  64'(rsp_data_o),    64'h0);
    checkOutput("midrst_ren",   64'(ddr_r_en_o),    64'h0);
    checkOutput("midrst_addr",  64'(ddr_address_o), 64'h0);
    checkOutput("midrst_err",   64'(err_o),         64'h0);
    rst_i = 1'b0;
    applyStimulus(4'b0000, 1'b0, 1'b1, 64'hEE);
    nextCycle();
    applyStimulus(4'b0000, 1'b0, 1'b0, 64'h0);
    checkOutput("late_err", 64'(err_o),       64'h1);
    checkOutput("late_rsp", 64'(rsp_valid_o), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_made, fail_count);
    $finish;
  end

endmodule
